// File: rtl/ftc_bus_enc.sv
// ftc_bus_enc: pipelined 3b->4b forbidden-transition-code bus encoder
// with optional shield wires, 2-entry skid buffer and word counter.
module ftc_bus_enc #(
  parameter int NGROUPS = 4,
  parameter int SHIELD  = 1,
  parameter int CNT_W   = 16,
  localparam int S      = (SHIELD != 0) ? 1 : 0,
  localparam int OW     = 4*NGROUPS + S*(NGROUPS-1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*NGROUPS-1:0] in_data,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OW-1:0]      out_data,
  output logic [CNT_W-1:0]   word_cnt
);

  logic          ovld;
  logic          svld;
  logic [OW-1:0] odata;
  logic [OW-1:0] sdata;
  logic [OW-1:0] enc;
  logic          accept;
  logic          xfer;

  function automatic logic [3:0] ftc(input logic [2:0] v);
    logic [3:0] c;
    unique case (v)
      3'd0: c = 4'b0000;
      3'd1: c = 4'b0100;
      3'd2: c = 4'b0001;
      3'd3: c = 4'b0101;
      3'd4: c = 4'b0111;
      3'd5: c = 4'b1100;
      3'd6: c = 4'b1101;
      3'd7: c = 4'b1111;
    endcase
    return c;
  endfunction

  // Encode every group (or pass raw data) straight off the input.
  always_comb begin
    enc = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      if (in_bypass)
        enc[4*g+S*g +: 4] = {1'b0, in_data[3*g +: 3]};
      else
        enc[4*g+S*g +: 4] = ftc(in_data[3*g +: 3]);
    end
  end

  assign in_ready  = !svld && !rst;
  assign accept    = in_valid && in_ready;
  assign xfer      = ovld && out_ready;
  assign out_valid = ovld;
  assign out_data  = odata;

  // Output/skid register pair: skid drains first, keeping FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovld  <= 1'b0;
      svld  <= 1'b0;
      odata <= '0;
      sdata <= '0;
    end else if (xfer && svld) begin
      odata <= sdata;
      svld  <= 1'b0;
    end else if (accept && (!ovld || xfer)) begin
      odata <= enc;
      ovld  <= 1'b1;
    end else if (accept) begin
      sdata <= enc;
      svld  <= 1'b1;
    end else if (xfer) begin
      ovld  <= 1'b0;
    end
  end

  // Accepted-word counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)
      word_cnt <= '0;
    else if (accept)
      word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ftc_bus_enc.sv
// tb_ftc_bus_enc: randomized + directed bench for ftc_bus_enc,
// checked against a FIFO-level reference model.
module tb_ftc_bus_enc;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       in_bypass;
  logic       out_ready;
  logic [5:0] in_data;

  logic       a_rdy, a_vld;
  logic [8:0] a_dat;
  logic [3:0] a_cnt;
  logic       b_rdy, b_vld;
  logic [7:0] b_dat;
  logic [3:0] b_cnt;

  ftc_bus_enc #(.NGROUPS(2), .SHIELD(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_rdy),
    .in_data(in_data), .in_bypass(in_bypass),
    .out_valid(a_vld), .out_ready(out_ready),
    .out_data(a_dat), .word_cnt(a_cnt)
  );

  ftc_bus_enc #(.NGROUPS(2), .SHIELD(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_rdy),
    .in_data(in_data), .in_bypass(in_bypass),
    .out_valid(b_vld), .out_ready(out_ready),
    .out_data(b_dat), .word_cnt(b_cnt)
  );

  typedef struct {
    logic [5:0] d;
    logic       byp;
  } item_t;

  item_t      q[$];
  int         cnt_m;
  int         n_chk;
  int         n_fail;
  logic [8:0] prev_a;
  logic       prev_ok;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lut(input int v);
    int t[8] = '{0, 4, 1, 5, 7, 12, 13, 15};
    return t[v];
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] d,
                                           input logic byp,
                                           input int sh);
    int r = 0;
    for (int g = 0; g < 2; g++) begin
      int v = (int'(d) >> (3*g)) & 7;
      int c = byp ? v : lut(v);
      r = r + c * (1 << (g*(4+sh)));
    end
    return 32'(r);
  endfunction

  function automatic logic ftc_bad(input logic [8:0] p,
                                   input logic [8:0] c);
    logic bad = 1'b0;
    for (int g = 0; g < 2; g++) begin
      logic [3:0] pc = p[5*g +: 4];
      logic [3:0] cc = c[5*g +: 4];
      for (int i = 0; i < 3; i++) begin
        if ({pc[i+1], pc[i]} == 2'b01 && {cc[i+1], cc[i]} == 2'b10)
          bad = 1'b1;
        if ({pc[i+1], pc[i]} == 2'b10 && {cc[i+1], cc[i]} == 2'b01)
          bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // Check outputs against the model, then advance model and clock.
  task automatic cycle();
    logic rdy_e, acc, xf;
    #1;
    rdy_e = !rst && (q.size() < 2);
    chk("a_in_ready", 32'(a_rdy), 32'(rdy_e));
    chk("b_in_ready", 32'(b_rdy), 32'(rdy_e));
    chk("a_out_valid", 32'(a_vld), 32'(q.size() > 0));
    chk("b_out_valid", 32'(b_vld), 32'(q.size() > 0));
    chk("a_word_cnt", 32'(a_cnt), 32'(cnt_m));
    chk("b_word_cnt", 32'(b_cnt), 32'(cnt_m));
    if (q.size() > 0) begin
      chk("a_out_data", 32'(a_dat), ref_word(q[0].d, q[0].byp, 1));
      chk("b_out_data", 32'(b_dat), ref_word(q[0].d, q[0].byp, 0));
    end
    if (rst) begin
      q.delete();
      cnt_m   = 0;
      prev_ok = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      xf  = (q.size() > 0) && out_ready;
      if (xf) begin
        if (!q[0].byp) begin
          if (prev_ok)
            chk("ftc_transition", 32'(ftc_bad(prev_a, a_dat)), 0);
          prev_a  = a_dat;
          prev_ok = 1'b1;
        end else begin
          prev_ok = 1'b0;
        end
        void'(q.pop_front());
      end
      if (acc) begin
        item_t it;
        it.d   = in_data;
        it.byp = in_bypass;
        q.push_back(it);
        cnt_m = (cnt_m + 1) % 16;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    cnt_m     = 0;
    prev_ok   = 1'b0;
    prev_a    = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_a_data", 32'(a_dat), 0);
    chk("rst_b_data", 32'(b_dat), 0);

    // Single word example
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'b101_011;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("ex1_valid", 32'(a_vld), 1);
    chk("ex1_data", 32'(a_dat), 32'(9'b1100_0_0101));
    cycle();

    // Bypass then encoded, same data
    in_valid  = 1'b1;
    in_data   = 6'b111_010;
    in_bypass = 1'b1;
    cycle();
    chk("byp_data", 32'(b_dat), 32'(8'b0111_0010));
    in_bypass = 1'b0;
    cycle();
    chk("enc_data", 32'(b_dat), 32'(8'b1111_0001));
    in_valid = 1'b0;
    cycle();

    // Back-pressure, stream 0..3
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 6'd0;
    cycle();
    in_data = 6'd1;
    cycle();
    chk("bp_in_ready", 32'(a_rdy), 0);
    in_data = 6'd2;
    cycle();
    chk("bp_hold", 32'(a_dat), ref_word(6'd0, 1'b0, 1));
    out_ready = 1'b1;
    cycle();
    chk("bp_w1", 32'(a_dat), ref_word(6'd1, 1'b0, 1));
    cycle();
    chk("bp_w2", 32'(a_dat), ref_word(6'd2, 1'b0, 1));
    in_data = 6'd3;
    cycle();
    chk("bp_w3", 32'(a_dat), ref_word(6'd3, 1'b0, 1));
    in_valid = 1'b0;
    cycle();

    // Counter wrap: 17 words after reset
    rst = 1'b1;
    cycle();
    rst      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 6'(i * 5);
      cycle();
    end
    in_valid = 1'b0;
    chk("cnt_wrap", 32'(a_cnt), 1);
    cycle();

    // Exhaustive table sweep through both groups
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 6'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    // Mid-operation reset with both registers full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'd9;
    cycle();
    in_data = 6'd17;
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(a_rdy), 0);
    cycle();
    chk("mid_rst_vld", 32'(a_vld), 0);
    chk("mid_rst_cnt", 32'(a_cnt), 0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(a_rdy), 1);
    cycle();
    chk("post_rst_vld", 32'(a_vld), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_bypass = ($urandom_range(0, 3) == 0);
      in_data   = 6'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
